// File: rtl/div_ctrl_pkg.sv
// Shared types and helpers for the runtime-programmable clock divider.
// Optional build macro used by div_ctrl: DIV_CTRL_STATS_EN.
package div_ctrl_pkg;

  // Default width of the period counter and of the divide/duty fields.
  localparam int DEF_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_e;

  // One divider configuration; sized by DEF_CNT_W, so div_ctrl is built
  // with CNT_W equal to DEF_CNT_W.
  typedef struct packed {
    logic [DEF_CNT_W-1:0] div;
    logic [DEF_CNT_W-1:0] duty;
  } cfg_t;

  // A configuration is usable when the period is at least two cycles and
  // the high time fits inside the period.
  function automatic logic cfg_ok(cfg_t c);
    return (c.div >= DEF_CNT_W'(2)) && (c.duty <= c.div);
  endfunction

endpackage

// File: rtl/div_ctrl_if.sv
// Configuration channel into div_ctrl. Signal names are from div_ctrl's
// point of view (i_ = into the divider, o_ = out of it).
interface div_ctrl_if #(parameter int CNT_W = 16);

  // Handshake: a transfer happens on a rising i_clk edge where
  // i_cfg_valid && o_cfg_ready. The requester holds i_cfg_valid and the
  // data stable until that edge. o_cfg_err pulses for one cycle right
  // after a transfer whose data was rejected.
  logic             i_cfg_valid;
  logic             o_cfg_ready;
  logic [CNT_W-1:0] i_cfg_div;
  logic [CNT_W-1:0] i_cfg_duty;
  logic             o_cfg_err;

  modport master (output i_cfg_valid, i_cfg_div, i_cfg_duty,
                  input  o_cfg_ready, o_cfg_err);

  modport slave  (input  i_cfg_valid, i_cfg_div, i_cfg_duty,
                  output o_cfg_ready, o_cfg_err);

endinterface

// File: rtl/div_cnt_core.sv
// Period counter, active (divide, duty) registers and registered output
// decode. Outputs decode the current count, so they lag it by one cycle.
module div_cnt_core
  import div_ctrl_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int DEF_DIV  = 16,
  parameter int DEF_DUTY = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  cfg_t i_cfg,
  input  logic i_run,
  output logic o_tc,
  output logic o_clk_div,
  output logic o_tick
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_div;
  logic [CNT_W-1:0] r_duty;
  logic             r_clk_div;
  logic             r_tick;

  // Terminal count: last cycle of the current period.
  assign o_tc = i_run && (r_cnt == (r_div - CNT_W'(1)));

  // Count while running, wrap at the period end, hold at zero when idle.
  always_ff @(posedge i_clk) begin
    if (i_rst || !i_run || o_tc) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Active configuration; only reloaded at a period boundary or when idle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_div  <= CNT_W'(DEF_DIV);
      r_duty <= CNT_W'(DEF_DUTY);
    end else if (i_load) begin
      r_div  <= CNT_W'(i_cfg.div);
      r_duty <= CNT_W'(i_cfg.duty);
    end
  end

  // Registered decode of the divided clock and the period-start tick.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_clk_div <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      r_clk_div <= i_run && (r_cnt < r_duty);
      r_tick    <= i_run && (r_cnt == '0);
    end
  end

  assign o_clk_div = r_clk_div;
  assign o_tick    = r_tick;

endmodule

// File: rtl/div_ctrl.sv
// Runtime-programmable clock-divider controller: FSM, config handshake,
// shadow register and error pulse around div_cnt_core.
// Optional macro DIV_CTRL_STATS_EN adds o_period_cnt (completed periods).
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int DEF_DIV  = 16,
  parameter int DEF_DUTY = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_en,
  div_ctrl_if.slave   cfg,
  output logic        o_clk_div,
  output logic        o_tick,
  output logic        o_busy,
`ifdef DIV_CTRL_STATS_EN
  output logic [31:0] o_period_cnt,
`endif
  output state_e      o_dbg_state
);

  state_e r_state;
  state_e w_state_next;
  cfg_t   r_shadow;
  cfg_t   w_cfg;
  cfg_t   w_load_cfg;
  logic   w_xfer;
  logic   w_ok;
  logic   w_load;
  logic   w_shadow_we;
  logic   w_tc;
  logic   r_err;

  assign w_cfg.div      = DEF_CNT_W'(cfg.i_cfg_div);
  assign w_cfg.duty     = DEF_CNT_W'(cfg.i_cfg_duty);
  assign cfg.o_cfg_ready = (r_state != PEND);
  assign cfg.o_cfg_err   = r_err;
  assign w_xfer         = cfg.i_cfg_valid && cfg.o_cfg_ready;
  assign w_ok           = cfg_ok(w_cfg);
  assign o_busy         = (r_state != IDLE);
  assign o_dbg_state    = r_state;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state plus load/shadow strobes. A config accepted while running
  // waits in the shadow register until the period ends; a config accepted
  // on the very cycle a run stops goes straight to the active registers.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_load_cfg   = w_cfg;
    w_shadow_we  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_xfer && w_ok) w_load = 1'b1;
        if (i_en) w_state_next = RUN;
      end
      RUN: begin
        if (w_xfer && w_ok) begin
          if (w_tc && !i_en) begin
            w_load       = 1'b1;
            w_state_next = IDLE;
          end else begin
            w_shadow_we  = 1'b1;
            w_state_next = PEND;
          end
        end else if (w_tc && !i_en) begin
          w_state_next = IDLE;
        end
      end
      PEND: begin
        if (w_tc) begin
          w_load       = 1'b1;
          w_load_cfg   = r_shadow;
          w_state_next = i_en ? RUN : IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Shadow config and the one-cycle rejection pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shadow <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_shadow_we) r_shadow <= w_cfg;
      r_err <= w_xfer && !w_ok;
    end
  end

  div_cnt_core #(
    .CNT_W    (CNT_W),
    .DEF_DIV  (DEF_DIV),
    .DEF_DUTY (DEF_DUTY)
  ) u_core (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_load    (w_load),
    .i_cfg     (w_load_cfg),
    .i_run     (o_busy),
    .o_tc      (w_tc),
    .o_clk_div (o_clk_div),
    .o_tick    (o_tick)
  );

`ifdef DIV_CTRL_STATS_EN
  logic [31:0] r_period_cnt;

  // Completed-period counter, saturating, restarted on every new run.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_period_cnt <= '0;
    end else if (r_state == IDLE && w_state_next == RUN) begin
      r_period_cnt <= '0;
    end else if (w_tc && (r_period_cnt != 32'hFFFF_FFFF)) begin
      r_period_cnt <= r_period_cnt + 32'd1;
    end
  end

  assign o_period_cnt = r_period_cnt;
`endif

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl. A period-level model predicts the
// whole output waveform of each period when it starts.
module tb_div_ctrl;
  import div_ctrl_pkg::*;

  localparam int W = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic en;
  always #5 clk = ~clk;

  div_ctrl_if #(.CNT_W(W)) cfg_bus ();

  logic   clk_div;
  logic   tick;
  logic   busy;
  state_e dbg_state;
`ifdef DIV_CTRL_STATS_EN
  logic [31:0] period_cnt;
`endif

  div_ctrl #(.CNT_W(W), .DEF_DIV(16), .DEF_DUTY(4)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_en        (en),
    .cfg         (cfg_bus),
    .o_clk_div   (clk_div),
    .o_tick      (tick),
    .o_busy      (busy),
`ifdef DIV_CTRL_STATS_EN
    .o_period_cnt(period_cnt),
`endif
    .o_dbg_state (dbg_state)
  );

  // ---------------- reference model ----------------
  logic [1:0] exp_q[$];   // {tick, clk_div} for each upcoming cycle
  int     m_div, m_duty, p_div, p_duty;
  bit     m_run, m_pend, m_err;
  bit     exp_tick, exp_clk;
  bit     xfer_seen;
  longint m_periods;
  int     n_checks = 0;
  int     n_fail   = 0;

  function automatic void push_period(int d, int du);
    for (int i = 0; i < d; i++) exp_q.push_back({(i == 0), (i < du)});
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    m_div = 16; m_duty = 4; m_run = 0; m_pend = 0; m_err = 0;
    exp_tick = 0; exp_clk = 0; m_periods = 0; xfer_seen = 0;
  endfunction

  // Applies one rising edge to the model using the inputs the bench drives.
  function automatic void model_edge();
    bit last = 0, had_pend, new_pend = 0;
    int nd = 0, ndu = 0;
    if (rst) begin model_reset(); return; end
    had_pend = m_pend;
    if (m_run) begin
      {exp_tick, exp_clk} = exp_q.pop_front();
      last = (exp_q.size() == 0);
    end else begin
      exp_tick = 0; exp_clk = 0;
    end
    m_err = 0; xfer_seen = 0;
    if (cfg_bus.i_cfg_valid && !m_pend) begin
      xfer_seen = 1;
      nd  = int'(cfg_bus.i_cfg_div);
      ndu = int'(cfg_bus.i_cfg_duty);
      if (nd < 2 || ndu > nd) m_err = 1;
      else if (!m_run) begin m_div = nd; m_duty = ndu; end
      else new_pend = 1;
    end
    if (!m_run) begin
      if (en) begin m_run = 1; m_periods = 0; push_period(m_div, m_duty); end
    end else if (last) begin
      if (m_periods < 64'hFFFF_FFFF) m_periods++;
      if (had_pend) begin m_div = p_div; m_duty = p_duty; m_pend = 0; end
      if (en) push_period(m_div, m_duty);
      else begin
        m_run = 0;
        if (new_pend) begin m_div = nd; m_duty = ndu; new_pend = 0; end
      end
    end
    if (new_pend) begin m_pend = 1; p_div = nd; p_duty = ndu; end
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    state_e exp_state;
    exp_state = !m_run ? IDLE : (m_pend ? PEND : RUN);
    chk("clk_div", 32'(clk_div), 32'(exp_clk));
    chk("tick", 32'(tick), 32'(exp_tick));
    chk("busy", 32'(busy), 32'(m_run));
    chk("cfg_ready", 32'(cfg_bus.o_cfg_ready), 32'(!m_pend));
    chk("cfg_err", 32'(cfg_bus.o_cfg_err), 32'(m_err));
    chk("state", 32'(dbg_state), 32'(exp_state));
`ifdef DIV_CTRL_STATS_EN
    chk("period_cnt", period_cnt, m_periods[31:0]);
`endif
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  task automatic run_cycles(int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic send_cfg(int d, int du);
    cfg_bus.i_cfg_valid = 1'b1;
    cfg_bus.i_cfg_div   = W'(d);
    cfg_bus.i_cfg_duty  = W'(du);
    for (int k = 0; k < 300; k++) begin
      cycle();
      if (xfer_seen) begin
        cfg_bus.i_cfg_valid = 1'b0;
        return;
      end
    end
    cfg_bus.i_cfg_valid = 1'b0;
    chk("cfg_xfer_timeout", 32'(cfg_bus.o_cfg_ready), 32'd1);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 300 && m_run; k++) cycle();
    chk("idle_wait", 32'(busy), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int target;
    rst = 1'b1; en = 1'b0;
    cfg_bus.i_cfg_valid = 1'b0;
    cfg_bus.i_cfg_div   = '0;
    cfg_bus.i_cfg_duty  = '0;
    model_reset();
    @(negedge clk);
    run_cycles(3);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(cfg_bus.o_cfg_ready), 32'd1);
    rst = 1'b0;

    // Default 16/4 run, then a mid-period change to 6/3.
    en = 1'b1;
    run_cycles(40);
    send_cfg(6, 3);
    run_cycles(30);

    // Rejected configs: div too small, duty above div.
    send_cfg(1, 0);
    run_cycles(3);
    send_cfg(5, 7);
    run_cycles(10);

    // Duty corners.
    send_cfg(8, 0);
    run_cycles(30);
    send_cfg(8, 8);
    run_cycles(30);

    // 10/5 then drop enable partway into a period.
    send_cfg(10, 5);
    for (int k = 0; k < 100 && !(!m_pend && exp_q.size() == 6); k++) cycle();
    en = 1'b0;
    wait_idle();
    run_cycles(5);

    // Reset while a config is pending restores defaults.
    en = 1'b1;
    run_cycles(5);
    send_cfg(12, 6);
    rst = 1'b1;
    run_cycles(2);
    rst = 1'b0;
    run_cycles(40);

    // Load 4/2 while idle and run; period counter checked every cycle.
    en = 1'b0;
    wait_idle();
    send_cfg(4, 2);
    en = 1'b1;
    run_cycles(41);
    target = 10;
`ifdef DIV_CTRL_STATS_EN
    chk("periods_40", period_cnt, 32'(target));
`endif
    en = 1'b0;
    wait_idle();
    run_cycles(2);

    // Enable and config in the same idle cycle.
    en = 1'b1;
    send_cfg(5, 2);
    run_cycles(20);

    // Randomized configs and enable toggling.
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 5) == 0) en = ~en;
      if ($urandom_range(0, 2) == 0)
        send_cfg(int'($urandom_range(0, 12)), int'($urandom_range(0, 14)));
      run_cycles(int'($urandom_range(1, 15)));
    end
    en = 1'b0;
    wait_idle();
    run_cycles(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
